sha256_msg_padder: RTL and testbench
====================================

# sha256_msg_padder

Byte-stream transmitter feeding the SHA-256 block processor's `data_in`/`data_valid`/`data_last` input. It accepts a raw message byte stream and forwards it unchanged. It then appends FIPS 180-4 padding: one 0x80 byte, 0x00 fill, and the 64-bit big-endian message bit length. Each emitted block is therefore exactly 64 bytes, and last is asserted only on the final byte of the final block. It also issues the processor's one-cycle start pulse ahead of the first byte.

## Interface
- `CNT_W`, default 32: width of the message byte counter. Length field = {(61-CNT_W) zeros, count, 3'b000}. Legal range 1..61.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a message; sampled only in IDLE.
- `start_empty`  in  1  qualifies `start`; 1 = zero-length message (no MSG phase).
- `msg_byte`  in  8  upstream message byte.
- `msg_valid`  in  1  upstream byte valid.
- `msg_last`  in  1  upstream byte is the final message byte; qualified by `msg_valid`.
- `msg_ready`  out  1  upstream transfer accepted when `msg_valid && msg_ready`.
- `proc_start`  out  1  one-cycle start pulse to the processor.
- `out_data`  out  8  byte to the processor.
- `out_valid`  out  1  `out_data` valid.
- `out_last`  out  1  final byte of the padded stream; qualified by `out_valid`.
- `out_ready`  in  1  downstream accepts; transfer = `out_valid && out_ready`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final padded byte transfers.

## Operation
- Registers: `state`; `pos[5:0]` (byte position in current block, wraps 63→0); `count[CNT_W-1:0]` (message bytes).
- IDLE:
  - All outputs 0.
  - On `start`: clear `pos` and `count`, latch `start_empty`, go to ARM.
  - `start` in any other state is ignored.
- ARM (1 cycle):
  - `proc_start`=1, `out_valid`=0, `msg_ready`=0.
  - Next state: PAD80 if the latched empty flag is set, else MSG.
- MSG: combinational pass-through.
  - `out_data`=`msg_byte`, `out_valid`=`msg_valid`, `msg_ready`=`out_ready`, `out_last`=0.
  - Per transfer: `count`++ (wraps mod 2^CNT_W), `pos`++.
  - Transfer with `msg_last` → PAD80.
- PAD80: `out_data`=0x80, `msg_ready`=0. On transfer: `pos`++; next state LEN if new `pos`==56, else ZERO.
- ZERO: `out_data`=0x00. On transfer: `pos`++; if `pos`==55 at transfer → LEN. Spans the block wrap when 0x80 landed at `pos`≥56.
- LEN:
  - `out_data` = len64[63-8k -: 8], with k = `pos`-56 and len64 = {count,3'b000} zero-extended.
  - `out_last`=1 when `pos`==63.
  - Transfer at `pos`==63 → IDLE; `done` pulses the following cycle.
- Padding-state outputs (PAD80, ZERO, LEN) come from registers only. `out_valid`=1 and `out_data` stays stable until the byte transfers.
- Total emitted bytes = 64·ceil((L+9)/64) for message length L.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE, `pos`=0, `count`=0. `proc_start`, `out_valid`, `out_last`, `msg_ready`, `busy`, `done` all 0.
- Reset mid-message aborts immediately: no `done` pulse, and no further bytes are emitted.
- Latency:
  - `start` sampled at edge T → `proc_start` high during cycle T+1 (ARM).
  - Earliest first `out_valid` in cycle T+2, so the processor is already loading.
- MSG is zero-latency pass-through; `msg_ready` must not depend on `msg_valid`.
- `out_ready` low in a padding state stalls with outputs held; `pos` does not advance.
- `msg_last` without `msg_valid` is ignored.
- Back-to-back: `start` may be asserted in the cycle `done` is high. It is accepted, because state is IDLE at that edge.
- Zero-length message: ARM → PAD80 directly; `count`=0, so all length bytes are 0x00.

## Test plan
- "abc" (61 62 63, last on 63), `out_ready`=1 → 64 bytes: 61 62 63 80, 52×00, 00×7, 18. `out_last` only on byte 64; `done` pulses once; `proc_start` once, 1 cycle after `start`.
- Empty message (`start_empty`=1) → 80, 62×00, 00; `out_last` on byte 64; no `msg_ready` asserted.
- 55-byte message → 0x80 at pos 55, no ZERO state, length bytes end with 01 B8; total 64.
- 56-byte message → 0x80 at pos 56, 7 zeros, wrap, 56 zeros, length ends 01 C0. Total 128; `out_last` only on byte 128.
- 64-byte message with random `out_ready` stalls → 0x80 at byte 65, length ends 02 00; `out_data` stable while stalled; upstream sees `msg_ready` mirror `out_ready`.
- `rst_n` low at byte 30 of a ZERO run → all outputs 0 next cycle, no `done`. A following `start` with "abc" reproduces scenario 1 exactly.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - SHA-256 message byte forwarder with FIPS 180-4 padding.
// Passes message bytes straight through, then emits 0x80, zero fill and the 64-bit bit length.
module sha256_msg_padder #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       start_empty,
  input  logic [7:0] msg_byte,
  input  logic       msg_valid,
  input  logic       msg_last,
  output logic       msg_ready,
  output logic       proc_start,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_MSG,
    S_PAD80,
    S_ZERO,
    S_LEN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_pos;
  logic [CNT_W-1:0] r_count;
  logic             r_empty;
  logic             r_done;
  logic             w_xfer;
  logic [63:0]      w_len64;
  logic [7:0]       w_len_byte;

  assign w_len64    = {{(64-CNT_W){1'b0}}, r_count} << 3;
  // Length byte k (pos 56+k) is big-endian, so it sits at bit offset 8*(7-k).
  assign w_len_byte = w_len64[{~r_pos[2:0], 3'b000} +: 8];
  assign w_xfer     = out_valid && out_ready;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pos   <= 6'd0;
      r_count <= '0;
      r_empty <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == S_LEN) && out_ready && (r_pos == 6'd63);
      if (r_state == S_IDLE) begin
        if (start) begin
          r_pos   <= 6'd0;
          r_count <= '0;
          r_empty <= start_empty;
        end
      end else if (w_xfer) begin
        r_pos <= r_pos + 6'd1;
        if (r_state == S_MSG) begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    msg_ready   = 1'b0;
    proc_start  = 1'b0;
    out_data    = 8'h00;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        proc_start  = 1'b1;
        w_state_nxt = r_empty ? S_PAD80 : S_MSG;
      end
      S_MSG: begin
        out_data  = msg_byte;
        out_valid = msg_valid;
        msg_ready = out_ready;
        if (msg_valid && out_ready && msg_last) w_state_nxt = S_PAD80;
      end
      S_PAD80: begin
        out_data  = 8'h80;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = (r_pos == 6'd55) ? S_LEN : S_ZERO;
      end
      S_ZERO: begin
        out_valid = 1'b1;
        if (out_ready && r_pos == 6'd55) w_state_nxt = S_LEN;
      end
      S_LEN: begin
        out_data  = w_len_byte;
        out_valid = 1'b1;
        out_last  = (r_pos == 6'd63);
        if (out_ready && r_pos == 6'd63) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - randomized bench for sha256_msg_padder against a padding model.
module tb_sha256_msg_padder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start_empty;
  logic [7:0] msg_byte;
  logic       msg_valid;
  logic       msg_last;
  logic       msg_ready;
  logic       proc_start;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       busy;
  logic       done;

  int         vec_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] msg_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sha256_msg_padder #(.CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_empty(start_empty),
    .msg_byte   (msg_byte),
    .msg_valid  (msg_valid),
    .msg_last   (msg_last),
    .msg_ready  (msg_ready),
    .proc_start (proc_start),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic fill(input int n);
    msg_q.delete();
    repeat (n) msg_q.push_back(8'($urandom));
  endtask

  // Padded stream: message, 0x80, zeros up to 56 mod 64, then 64-bit big-endian bit length.
  task automatic build_exp();
    logic [63:0] bits;
    exp_q.delete();
    foreach (msg_q[i]) exp_q.push_back(msg_q[i]);
    exp_q.push_back(8'h80);
    while ((exp_q.size() % 64) != 56) exp_q.push_back(8'h00);
    bits = 64'(msg_q.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) exp_q.push_back(bits[8*i +: 8]);
  endtask

  task automatic run_msg(input bit rnd, input int abort_at);
    int len = msg_q.size();
    int idx = 0;
    int up  = 0;
    int cyc = 0;
    build_exp();
    start       = 1'b1;
    start_empty = (len == 0);
    @(negedge clk);
    start       = 1'b0;
    start_empty = 1'b0;
    msg_valid   = 1'b0;
    out_ready   = 1'b1;
    #1;
    chk("arm_proc_start", proc_start, 1);
    chk("arm_out_valid", out_valid, 0);
    chk("arm_msg_ready", msg_ready, 0);
    chk("arm_busy", busy, 1);
    while (idx < exp_q.size()) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        chk("timeout", idx, exp_q.size());
        return;
      end
      if (abort_at >= 0 && idx == abort_at) begin
        rst_n     = 1'b0;
        msg_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_proc_start", proc_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_msg_ready", msg_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          #1;
          chk("post_rst_out_valid", out_valid, 0);
          chk("post_rst_done", done, 0);
        end
        return;
      end
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      msg_valid = (up < len) ? (rnd ? ($urandom_range(0, 3) != 0) : 1'b1) : 1'b0;
      if (msg_valid) begin
        msg_byte = msg_q[up];
        msg_last = (up == len - 1);
      end else begin
        msg_byte = 8'($urandom);
        msg_last = 1'($urandom);
      end
      #1;
      chk("msg_ready", msg_ready, (up < len) ? out_ready : 1'b0);
      chk("out_valid", out_valid, (up < len) ? msg_valid : 1'b1);
      chk("proc_start", proc_start, 0);
      chk("done_early", done, 0);
      if (out_valid) begin
        chk("out_data", out_data, exp_q[idx]);
        chk("out_last", out_last, (idx == exp_q.size() - 1));
      end
      if (msg_valid && msg_ready) up++;
      if (out_valid && out_ready) idx++;
    end
    @(negedge clk);
    msg_valid = 1'b0;
    #1;
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_out_valid", out_valid, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    start_empty = 1'b0;
    msg_byte    = 8'h00;
    msg_valid   = 1'b0;
    msg_last    = 1'b0;
    out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_proc_start", proc_start, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_msg_ready", msg_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(1'b0, -1);
    msg_q.delete();
    run_msg(1'b0, -1);
    fill(55);
    run_msg(1'b0, -1);
    fill(56);
    run_msg(1'b0, -1);
    fill(64);
    run_msg(1'b1, -1);
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(1'b0, 33);
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(1'b0, -1);
    repeat (6) begin
      fill($urandom_range(0, 140));
      run_msg(1'b1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
